apb_master_bridge: RTL and testbench

- Single-transfer APB requester: the initiating end of the APB register bus our peripheral slaves sit on.
- Accepts one read or write command at a time from a local controller over a valid/ready port.
- Drives the APB SETUP/ACCESS sequence, waits for pready, and returns read data plus an error flag.
- Includes a watchdog so a hung slave cannot stall the controller.

---
 rtl/apb_master_bridge.sv | 158 +++++++++++++++
 tb/tb_apb_master_bridge.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-transfer APB requester with pready watchdog
module apb_master_bridge #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  // Counter must be able to hold TIMEOUT-1; a zero TIMEOUT keeps a dummy bit.
  localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit               WDOG_EN  = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = WDOG_EN ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              wdog_fire;

  // Abort when the last permitted ACCESS cycle still sees no pready.
  assign wdog_fire = WDOG_EN && (state_q == S_ACCESS) && !pready && (cnt_q == CNT_LAST);

  // State register.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection for the SETUP/ACCESS sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (cmd_valid) state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: if (pready || wdog_fire) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Next values of the registered bus, response and watchdog signals.
  always_comb begin
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (cmd_valid) begin
          psel_d   = 1'b1;
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      S_ACCESS: begin
        if (pready) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = pslverr;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
        end else if (wdog_fire) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  // Output and watchdog registers; reset wipes any transfer in flight.
  always_ff @(posedge pclk) begin
    if (preset) begin
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      cnt_q       <= '0;
    end else begin
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - bench for apb_master_bridge with transaction timeline model
module tb_apb_master_bridge;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 16;

  logic          pclk = 1'b0;
  logic          preset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [DW-1:0] prdata = '0;
  logic          pready = 1'b0;
  logic          pslverr = 1'b0;
  logic          cmd_ready, rsp_valid, rsp_err, psel, penable, pwrite;
  logic [DW-1:0] rsp_rdata, pwdata;
  logic [AW-1:0] paddr;

  apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  int errors = 0;
  int checks = 0;

  // Slave behaviour for the current transfer: wait states before pready, data, error.
  int            slv_wait = 0;
  logic [DW-1:0] slv_rdata = '0;
  logic          slv_err = 1'b0;

  // Model: timeline of the current transfer in absolute cycle numbers.
  int            cyc = 0;
  int            free_at = 0;
  int            acc = 0;
  bit            pending = 1'b0;
  logic          e_pwrite = 1'b0;
  logic [AW-1:0] e_paddr = '0;
  logic [DW-1:0] e_pwdata = '0;
  logic [DW-1:0] p_rdata = '0;
  logic          p_err = 1'b0;
  logic [DW-1:0] h_rdata = '0;
  logic          h_err = 1'b0;
  int            m_c, m_k, m_len;
  bit            m_to, e_busy, e_valid;

  // Monitor records.
  int            n_psel = 0;
  int            n_pen = 0;
  int            rq_cyc[$];
  logic [DW-1:0] rq_rdata[$];
  logic          rq_err[$];
  int            seen = 0;
  int            setup_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model update on each rising edge, compare against DUT on each falling edge.
  initial begin
    forever begin
      @(posedge pclk);
      m_c = cyc;
      if (preset) begin
        pending  = 1'b0;
        free_at  = m_c + 1;
        acc      = m_c + 1;
        e_pwrite = 1'b0;
        e_paddr  = '0;
        e_pwdata = '0;
        h_rdata  = '0;
        h_err    = 1'b0;
      end else if (m_c >= free_at && cmd_valid) begin
        m_to     = (TO != 0) && (slv_wait >= TO);
        m_len    = m_to ? TO : slv_wait + 1;
        acc      = m_c + 1;
        free_at  = acc + m_len + 1;
        pending  = 1'b1;
        e_pwrite = cmd_write;
        e_paddr  = cmd_addr;
        e_pwdata = cmd_wdata;
        p_rdata  = (m_to || cmd_write) ? '0 : slv_rdata;
        p_err    = m_to ? 1'b1 : slv_err;
      end
      cyc = m_c + 1;

      @(negedge pclk);
      m_k     = cyc;
      e_busy  = m_k < free_at;
      e_valid = pending && (m_k == free_at);
      if (e_valid) begin
        h_rdata = p_rdata;
        h_err   = p_err;
        pending = 1'b0;
      end
      chk("psel", psel, e_busy);
      chk("penable", penable, e_busy && (m_k > acc));
      chk("cmd_ready", cmd_ready, !e_busy);
      chk("rsp_valid", rsp_valid, e_valid);
      chk("pwrite", pwrite, e_pwrite);
      chk("paddr", paddr, e_paddr);
      chk("pwdata", pwdata, e_pwdata);
      chk("rsp_rdata", rsp_rdata, h_rdata);
      chk("rsp_err", rsp_err, h_err);
      if (psel) n_psel++;
      if (penable) n_pen++;
      if (rsp_valid) begin
        rq_cyc.push_back(m_k);
        rq_rdata.push_back(rsp_rdata);
        rq_err.push_back(rsp_err);
      end
    end
  end

  // APB slave: counts ACCESS cycles, garbage data/error while not ready.
  initial begin
    int acc_n;
    acc_n = 0;
    forever begin
      @(negedge pclk);
      if (psel && penable) begin
        pready  = (acc_n == slv_wait);
        prdata  = pready ? slv_rdata : ~slv_rdata;
        pslverr = pready ? slv_err : 1'b1;
        acc_n++;
      end else begin
        acc_n   = 0;
        pready  = 1'b0;
        prdata  = '0;
        pslverr = 1'b0;
      end
    end
  end

  task automatic send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit keep);
    bit ok;
    ok = 1'b0;
    @(negedge pclk);
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge pclk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no cmd_ready expected accept within 200 cycles");
    end
    @(posedge pclk);
    #1;
    setup_cyc = cyc;
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic take_rsp(output int lat, output int rc, output logic [DW-1:0] rd, output logic er);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (rq_cyc.size() > seen) begin
        ok = 1'b1;
        break;
      end
      @(posedge pclk);
      #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: got no rsp_valid expected one within 100 cycles");
      lat = -1;
      rc  = -1;
      rd  = 'x;
      er  = 1'bx;
    end else begin
      rc  = rq_cyc[seen];
      lat = rc - setup_cyc + 1;
      rd  = rq_rdata[seen];
      er  = rq_err[seen];
      seen++;
    end
  endtask

  initial begin
    int lat, rc1, rc2, s_psel, s_pen, nrsp;
    logic [DW-1:0] rd;
    logic er;

    repeat (2) @(posedge pclk);
    @(negedge pclk);
    preset = 1'b0;
    @(posedge pclk);
    #1;
    chk("rst_psel", psel, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_paddr", paddr, 0);

    // Write, zero wait states.
    slv_wait = 0; slv_rdata = 8'h11; slv_err = 1'b0;
    s_psel = n_psel; s_pen = n_pen;
    send(1'b1, 8'h03, 8'hA5, 1'b0);
    take_rsp(lat, rc1, rd, er);
    chk("wr0_latency", lat, 3);
    chk("wr0_psel_cycles", n_psel - s_psel, 2);
    chk("wr0_penable_cycles", n_pen - s_pen, 1);
    chk("wr0_rdata", rd, 8'h00);
    chk("wr0_err", er, 0);

    // Read, two wait states.
    slv_wait = 2; slv_rdata = 8'h3C; slv_err = 1'b0;
    s_pen = n_pen;
    send(1'b0, 8'h01, 8'h00, 1'b0);
    take_rsp(lat, rc1, rd, er);
    chk("rd2_latency", lat, 5);
    chk("rd2_penable_cycles", n_pen - s_pen, 3);
    chk("rd2_rdata", rd, 8'h3C);
    chk("rd2_err", er, 0);

    // Read with slave error.
    slv_wait = 0; slv_rdata = 8'h77; slv_err = 1'b1;
    send(1'b0, 8'h10, 8'h00, 1'b0);
    take_rsp(lat, rc1, rd, er);
    chk("rderr_err", er, 1);
    chk("rderr_rdata", rd, 8'h77);

    // Write with slave error after one wait state.
    slv_wait = 1; slv_rdata = 8'h66; slv_err = 1'b1;
    send(1'b1, 8'h20, 8'hC3, 1'b0);
    take_rsp(lat, rc1, rd, er);
    chk("wrerr_latency", lat, 4);
    chk("wrerr_err", er, 1);
    chk("wrerr_rdata", rd, 8'h00);

    // pready on the last cycle before the watchdog limit completes normally.
    slv_wait = TO - 1; slv_rdata = 8'h99; slv_err = 1'b0;
    s_pen = n_pen;
    send(1'b0, 8'h06, 8'h00, 1'b0);
    take_rsp(lat, rc1, rd, er);
    chk("edge_penable_cycles", n_pen - s_pen, 16);
    chk("edge_rdata", rd, 8'h99);
    chk("edge_err", er, 0);

    // Watchdog abort with pready stuck low.
    slv_wait = 1000; slv_rdata = 8'h42; slv_err = 1'b0;
    s_pen = n_pen;
    send(1'b0, 8'h05, 8'h00, 1'b0);
    take_rsp(lat, rc1, rd, er);
    chk("wdog_penable_cycles", n_pen - s_pen, 16);
    chk("wdog_latency", lat, 18);
    chk("wdog_err", er, 1);
    chk("wdog_rdata", rd, 8'h00);

    // Back-to-back writes with cmd_valid held.
    slv_wait = 0; slv_err = 1'b0;
    send(1'b1, 8'h03, 8'hA5, 1'b1);
    send(1'b1, 8'h04, 8'h5A, 1'b0);
    take_rsp(lat, rc1, rd, er);
    take_rsp(lat, rc2, rd, er);
    chk("b2b_gap", rc2 - rc1, 3);
    chk("b2b_err", er, 0);

    // Reset during ACCESS, then a normal read.
    slv_wait = 1000; slv_rdata = 8'h24;
    nrsp = rq_cyc.size();
    send(1'b0, 8'h08, 8'h00, 1'b0);
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    preset = 1'b1;
    @(negedge pclk);
    preset = 1'b0;
    @(posedge pclk);
    #1;
    chk("mrst_psel", psel, 0);
    chk("mrst_penable", penable, 0);
    chk("mrst_cmd_ready", cmd_ready, 1);
    chk("mrst_no_rsp", rq_cyc.size(), nrsp);
    slv_wait = 1; slv_rdata = 8'h5C; slv_err = 1'b0;
    send(1'b0, 8'h09, 8'h00, 1'b0);
    take_rsp(lat, rc1, rd, er);
    chk("post_rst_latency", lat, 4);
    chk("post_rst_rdata", rd, 8'h5C);
    chk("post_rst_err", er, 0);

    repeat (3) @(posedge pclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected end before 100000 time units");
    $fatal(1, "bench time limit reached");
  end

endmodule
